// File: rtl/tl_control_fsm.sv
// Transaction-layer control FSM: one-hot state bus for the FIFO referee,
// sanitised FIFO thresholds, and idle/error status from the 8 FIFO flag pairs.
module tl_control_fsm #(
    parameter int THR_W     = 3,
    parameter int IDLE_HOLD = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [THR_W-1:0] af_thr_in,
    input  logic [THR_W-1:0] ae_thr_in,
    input  logic [7:0]       empty_in,
    input  logic [7:0]       error_in,
    output logic [3:0]       state,
    output logic [THR_W-1:0] af_thr_out,
    output logic [THR_W-1:0] ae_thr_out,
    output logic             idle_out,
    output logic             error_out,
    output logic [7:0]       error_src
);

    localparam int CNT_W = (IDLE_HOLD < 1) ? 1 : $clog2(IDLE_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(IDLE_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [THR_W-1:0] THR_ONE  = THR_W'(1);

    typedef enum logic [3:0] {
        S_RESET  = 4'b0001,
        S_INIT   = 4'b0010,
        S_IDLE   = 4'b0100,
        S_ACTIVE = 4'b1000,
        S_ERROR  = 4'b0000
    } state_t;

    state_t             state_q, state_d;
    logic [THR_W-1:0]   af_q, af_d, ae_q, ae_d;
    logic [THR_W-1:0]   af_san, ae_san;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [7:0]         src_q, src_d;
    logic               idle_q, err_q;

    // Almost-full of 0 is meaningless; almost-empty must sit strictly below almost-full.
    assign af_san  = (af_thr_in == '0) ? THR_ONE : af_thr_in;
    assign ae_san  = (ae_thr_in >= af_san) ? (af_san - THR_ONE) : ae_thr_in;
    assign cnt_inc = (cnt_q >= HOLD_C) ? HOLD_C : (cnt_q + CNT_ONE);

    always_comb begin
        state_d = state_q;
        af_d    = af_q;
        ae_d    = ae_q;
        cnt_d   = '0;
        src_d   = src_q;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                af_d = af_san;
                ae_d = ae_san;
                if (!init) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (|error_in) begin
                    state_d = S_ERROR;
                    src_d   = error_in;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (empty_in != 8'hFF) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (|error_in) begin
                    state_d = S_ERROR;
                    src_d   = error_in;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (empty_in == 8'hFF) begin
                    // Counter is left at 0 on the drop to IDLE since the state changes.
                    if (cnt_inc == HOLD_C) state_d = S_IDLE;
                    else                   cnt_d   = cnt_inc;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            af_q    <= THR_ONE;
            ae_q    <= '0;
            cnt_q   <= '0;
            src_q   <= '0;
            idle_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            idle_q  <= (state_d == S_IDLE);
            err_q   <= (state_d == S_ERROR);
        end
    end

    assign state      = state_q;
    assign af_thr_out = af_q;
    assign ae_thr_out = ae_q;
    assign idle_out   = idle_q;
    assign error_out  = err_q;
    assign error_src  = src_q;

endmodule

// File: tb/tb_tl_control_fsm.sv
// Directed bench for tl_control_fsm: a vector table walked edge by edge,
// then hand sequences for reset-from-ACTIVE and idle-counter clearing.
module tb_tl_control_fsm;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [2:0] af_thr_in, ae_thr_in, af_thr_out, ae_thr_out;
    logic [7:0] empty_in, error_in, error_src;
    logic [3:0] state;
    logic       idle_out, error_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] RST = 4'b0001, INI = 4'b0010, IDL = 4'b0100,
                           ACT = 4'b1000, ERR = 4'b0000;

    tl_control_fsm #(.THR_W(3), .IDLE_HOLD(2)) dut (
        .clk(clk), .reset(reset), .init(init),
        .af_thr_in(af_thr_in), .ae_thr_in(ae_thr_in),
        .empty_in(empty_in), .error_in(error_in),
        .state(state), .af_thr_out(af_thr_out), .ae_thr_out(ae_thr_out),
        .idle_out(idle_out), .error_out(error_out), .error_src(error_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ini;
        logic [2:0] af;
        logic [2:0] ae;
        logic [7:0] emp;
        logic [7:0] err;
        logic [3:0] st;
        logic [2:0] eaf;
        logic [2:0] eae;
        logic       eidle;
        logic       eerr;
        logic [7:0] esrc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic ini, logic [2:0] af, logic [2:0] ae,
                                logic [7:0] emp, logic [7:0] err, logic [3:0] st,
                                logic [2:0] eaf, logic [2:0] eae, logic [7:0] esrc);
        vec_t v;
        v.rst = rst; v.ini = ini; v.af = af; v.ae = ae; v.emp = emp; v.err = err;
        v.st = st; v.eaf = eaf; v.eae = eae; v.esrc = esrc;
        v.eidle = (st == IDL);
        v.eerr  = (st == ERR);
        return v;
    endfunction

    task automatic chk(string tag, string what, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic apply_and_check(string tag, vec_t v);
        @(negedge clk);
        reset = v.rst; init = v.ini; af_thr_in = v.af; ae_thr_in = v.ae;
        empty_in = v.emp; error_in = v.err;
        @(posedge clk);
        #1;
        chk(tag, "state",      {4'b0, state},      {4'b0, v.st});
        chk(tag, "af_thr_out", {5'b0, af_thr_out}, {5'b0, v.eaf});
        chk(tag, "ae_thr_out", {5'b0, ae_thr_out}, {5'b0, v.eae});
        chk(tag, "idle_out",   {7'b0, idle_out},   {7'b0, v.eidle});
        chk(tag, "error_out",  {7'b0, error_out},  {7'b0, v.eerr});
        chk(tag, "error_src",  error_src,          v.esrc);
        $display("%s: rst=%b init=%b af_in=%0d ae_in=%0d empty=%h err=%h -> state=%b af=%0d ae=%0d idle=%b error=%b src=%h",
                 tag, v.rst, v.ini, v.af, v.ae, v.emp, v.err,
                 state, af_thr_out, ae_thr_out, idle_out, error_out, error_src);
    endtask

    initial begin
        reset = 1'b1; init = 1'b1; af_thr_in = 3'd0; ae_thr_in = 3'd0;
        empty_in = 8'hFF; error_in = 8'h00;

        //             rst ini af  ae  empty  err    state af  ae  src
        vecs.push_back(mk(1, 1, 5, 2, 8'hFF, 8'h00, RST, 1, 0, 8'h00));
        vecs.push_back(mk(1, 1, 5, 2, 8'hFF, 8'h00, RST, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 5, 2, 8'hFF, 8'h00, INI, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 5, 2, 8'hFF, 8'h00, INI, 5, 2, 8'h00));
        vecs.push_back(mk(0, 0, 5, 2, 8'hFF, 8'h00, IDL, 5, 2, 8'h00));
        vecs.push_back(mk(0, 0, 7, 6, 8'hFF, 8'h00, IDL, 5, 2, 8'h00));
        vecs.push_back(mk(0, 1, 0, 3, 8'hFF, 8'h00, INI, 5, 2, 8'h00));
        vecs.push_back(mk(0, 0, 0, 3, 8'hFF, 8'h00, IDL, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 4, 6, 8'hFF, 8'h00, INI, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 4, 6, 8'hFF, 8'h00, IDL, 4, 3, 8'h00));
        vecs.push_back(mk(0, 0, 4, 6, 8'hFE, 8'h00, ACT, 4, 3, 8'h00));
        vecs.push_back(mk(0, 0, 4, 6, 8'hFF, 8'h00, ACT, 4, 3, 8'h00));
        vecs.push_back(mk(0, 0, 4, 6, 8'h7F, 8'h00, ACT, 4, 3, 8'h00));
        vecs.push_back(mk(0, 0, 4, 6, 8'hFF, 8'h00, ACT, 4, 3, 8'h00));
        vecs.push_back(mk(0, 0, 4, 6, 8'hFF, 8'h00, IDL, 4, 3, 8'h00));
        vecs.push_back(mk(0, 0, 4, 6, 8'hEF, 8'h00, ACT, 4, 3, 8'h00));
        vecs.push_back(mk(0, 1, 4, 6, 8'hEF, 8'h00, INI, 4, 3, 8'h00));
        vecs.push_back(mk(0, 0, 7, 7, 8'hFF, 8'h00, IDL, 7, 6, 8'h00));
        vecs.push_back(mk(0, 0, 7, 7, 8'h00, 8'h00, ACT, 7, 6, 8'h00));
        vecs.push_back(mk(0, 1, 7, 7, 8'h00, 8'h10, ERR, 7, 6, 8'h10));
        vecs.push_back(mk(0, 1, 2, 1, 8'h00, 8'h00, ERR, 7, 6, 8'h10));
        vecs.push_back(mk(0, 0, 2, 1, 8'hFF, 8'h03, ERR, 7, 6, 8'h10));
        vecs.push_back(mk(1, 0, 2, 1, 8'hFF, 8'h00, RST, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 3, 1, 8'hFF, 8'hFF, INI, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 3, 1, 8'hFF, 8'h0F, INI, 3, 1, 8'h00));
        vecs.push_back(mk(0, 0, 3, 1, 8'hFF, 8'h00, IDL, 3, 1, 8'h00));
        vecs.push_back(mk(0, 0, 3, 1, 8'hFF, 8'h01, ERR, 3, 1, 8'h01));

        for (int i = 0; i < vecs.size(); i++)
            apply_and_check($sformatf("vec%0d", i), vecs[i]);

        // Reset taken from ACTIVE with a half-built idle count must clear it.
        apply_and_check("seqA0", mk(1, 0, 6, 2, 8'hFF, 8'h00, RST, 1, 0, 8'h00));
        apply_and_check("seqA1", mk(0, 1, 6, 2, 8'hFF, 8'h00, INI, 1, 0, 8'h00));
        apply_and_check("seqA2", mk(0, 0, 6, 2, 8'hFF, 8'h00, IDL, 6, 2, 8'h00));
        apply_and_check("seqA3", mk(0, 0, 6, 2, 8'h0F, 8'h00, ACT, 6, 2, 8'h00));
        apply_and_check("seqA4", mk(0, 0, 6, 2, 8'hFF, 8'h00, ACT, 6, 2, 8'h00));
        apply_and_check("seqA5", mk(1, 0, 6, 2, 8'hFF, 8'h00, RST, 1, 0, 8'h00));
        apply_and_check("seqA6", mk(0, 0, 6, 2, 8'hFF, 8'h00, INI, 1, 0, 8'h00));
        apply_and_check("seqA7", mk(0, 0, 6, 2, 8'hFF, 8'h00, IDL, 6, 2, 8'h00));
        apply_and_check("seqA8", mk(0, 0, 6, 2, 8'hFD, 8'h00, ACT, 6, 2, 8'h00));
        apply_and_check("seqA9", mk(0, 0, 6, 2, 8'hFF, 8'h00, ACT, 6, 2, 8'h00));
        apply_and_check("seqA10", mk(0, 0, 6, 2, 8'hFF, 8'h00, IDL, 6, 2, 8'h00));

        // Referee pop toggling: alternating empty/non-empty never reaches IDLE.
        apply_and_check("seqB0", mk(0, 0, 6, 2, 8'hBF, 8'h00, ACT, 6, 2, 8'h00));
        for (int k = 0; k < 6; k++)
            apply_and_check($sformatf("seqB%0d", k + 1),
                            mk(0, 0, 6, 2, (k % 2 == 0) ? 8'hFF : 8'hBF, 8'h00, ACT, 6, 2, 8'h00));

        // ACTIVE -> INIT with recapture, then error in ACTIVE at the same edge as all-empty.
        apply_and_check("seqC0", mk(0, 1, 6, 2, 8'hFF, 8'h00, INI, 6, 2, 8'h00));
        apply_and_check("seqC1", mk(0, 0, 2, 2, 8'hFF, 8'h00, IDL, 2, 1, 8'h00));
        apply_and_check("seqC2", mk(0, 0, 2, 2, 8'h01, 8'h00, ACT, 2, 1, 8'h00));
        apply_and_check("seqC3", mk(0, 0, 2, 2, 8'hFF, 8'h00, ACT, 2, 1, 8'h00));
        apply_and_check("seqC4", mk(0, 0, 2, 2, 8'hFF, 8'h80, ERR, 2, 1, 8'h80));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
